field_sweep_engine: RTL and testbench



---
 rtl/field_sweep_engine_pkg.sv | 30 +++
 rtl/life_rule_lane.sv | 25 ++
 rtl/field_sweep_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_field_sweep_engine.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/field_sweep_engine_pkg.sv
// Shared types and helpers for the Game of Life generation sweep engine.
package field_sweep_engine_pkg;

    localparam int unsigned NEIGHBOURS_CNT = 8;
    localparam int unsigned NBR_CNT_W      = 4;

    typedef enum logic {
        FIELD_A = 1'b0,
        FIELD_B = 1'b1
    } field_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } sweep_state_t;

    // Bit n selects the outcome for a cell with n live neighbours.
    typedef logic [NEIGHBOURS_CNT:0] rule_mask_t;

    function automatic logic [NBR_CNT_W-1:0] nbr_count(input logic [NEIGHBOURS_CNT-1:0] nbrs);
        logic [NBR_CNT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NEIGHBOURS_CNT; i++) begin
            cnt = cnt + NBR_CNT_W'(nbrs[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/life_rule_lane.sv
// Next state of one cell from its current state and neighbour bits.
// LIFE_RULE_PROG_EN selects mask-driven rules; otherwise the fixed B3/S23 rule.
module life_rule_lane
    import field_sweep_engine_pkg::*;
(
    input  logic                      cell_i,
    input  logic [NEIGHBOURS_CNT-1:0] nbrs_i,
`ifdef LIFE_RULE_PROG_EN
    input  rule_mask_t                birth_mask_i,
    input  rule_mask_t                survive_mask_i,
`endif
    output logic                      next_o
);

    logic [NBR_CNT_W-1:0] cnt;

    assign cnt = nbr_count(nbrs_i);

`ifdef LIFE_RULE_PROG_EN
    assign next_o = cell_i ? survive_mask_i[cnt] : birth_mask_i[cnt];
`else
    assign next_o = (cnt == NBR_CNT_W'(3)) || (cell_i && (cnt == NBR_CNT_W'(2)));
`endif

endmodule

// File: rtl/field_sweep_engine.sv
// Raster-sweeps the read field LANES cells per cycle, applies the life rule and writes the opposite field.
// Build option LIFE_RULE_PROG_EN adds birth/survive mask ports sampled at sweep start.
module field_sweep_engine
    import field_sweep_engine_pkg::*;
#(
    parameter int unsigned FIELD_W = 64,
    parameter int unsigned FIELD_H = 48,
    parameter int unsigned LANES   = 4,
    parameter int unsigned GEN_W   = 16,
    localparam int unsigned XW = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
    localparam int unsigned YW = (FIELD_H > 1) ? $clog2(FIELD_H) : 1,
    localparam int unsigned AW = $clog2(FIELD_W * FIELD_H + 1),
    localparam int unsigned NW = LANES * NEIGHBOURS_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_go,
    input  logic             i_run,
    input  logic             i_stop_on_stable,
    input  logic             i_stall,
    input  logic [LANES-1:0] i_cells,
    input  logic [NW-1:0]    i_nbrs,
`ifdef LIFE_RULE_PROG_EN
    input  rule_mask_t       i_birth_mask,
    input  rule_mask_t       i_survive_mask,
`endif
    output logic             o_busy,
    output logic             o_rd_en,
    output logic [XW-1:0]    o_rd_x,
    output logic [YW-1:0]    o_rd_y,
    output logic             o_wr_en,
    output logic [XW-1:0]    o_wr_x,
    output logic [YW-1:0]    o_wr_y,
    output logic [LANES-1:0] o_wr_cells,
    output field_t           o_read_field,
    output logic [GEN_W-1:0] o_gen_cnt,
    output logic [AW-1:0]    o_alive_cnt,
    output logic             o_gen_done,
    output logic             o_stable
);

    sweep_state_t     state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             stg_vld_q, stg_vld_d;
    logic [XW-1:0]    stg_x_q, stg_x_d;
    logic [YW-1:0]    stg_y_q, stg_y_d;
    logic [LANES-1:0] stg_cells_q, stg_cells_d;
    logic [NW-1:0]    stg_nbrs_q, stg_nbrs_d;
    logic [AW-1:0]    pop_acc_q, pop_acc_d;
    logic             chg_q, chg_d;
    field_t           read_field_q, read_field_d;
    logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
    logic [AW-1:0]    alive_q, alive_d;
    logic             gen_done_q, gen_done_d;
    logic             stable_q, stable_d;
`ifdef LIFE_RULE_PROG_EN
    rule_mask_t       birth_q, birth_d;
    rule_mask_t       survive_q, survive_d;
`endif

    logic             rd_fire;
    logic             wr_fire;
    logic [LANES-1:0] wr_cells;
    logic [AW-1:0]    wr_pop;
    logic [AW-1:0]    pop_sum;
    logic             chg_sum;

    assign rd_fire = (state_q == SWEEP) && !i_stall;
    assign wr_fire = stg_vld_q && !i_stall;

    // One rule evaluator per lane, fed from the registered write stage.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        life_rule_lane u_lane (
            .cell_i         (stg_cells_q[k]),
            .nbrs_i         (stg_nbrs_q[k*NEIGHBOURS_CNT +: NEIGHBOURS_CNT]),
`ifdef LIFE_RULE_PROG_EN
            .birth_mask_i   (birth_q),
            .survive_mask_i (survive_q),
`endif
            .next_o         (wr_cells[k])
        );
    end

    // Statistics including the write being accepted this cycle.
    always_comb begin
        wr_pop = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            wr_pop = wr_pop + AW'(wr_cells[k]);
        end
        pop_sum = pop_acc_q + (wr_fire ? wr_pop : AW'(0));
        chg_sum = chg_q || (wr_fire && (|(wr_cells ^ stg_cells_q)));
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        stg_vld_d    = stg_vld_q;
        stg_x_d      = stg_x_q;
        stg_y_d      = stg_y_q;
        stg_cells_d  = stg_cells_q;
        stg_nbrs_d   = stg_nbrs_q;
        pop_acc_d    = pop_sum;
        chg_d        = chg_sum;
        read_field_d = read_field_q;
        gen_cnt_d    = gen_cnt_q;
        alive_d      = alive_q;
        gen_done_d   = 1'b0;
        stable_d     = stable_q;
`ifdef LIFE_RULE_PROG_EN
        birth_d      = birth_q;
        survive_d    = survive_q;
`endif

        // Stage empties on an accepted write unless refilled by this cycle's read.
        if (wr_fire) begin
            stg_vld_d = 1'b0;
        end
        if (rd_fire) begin
            stg_vld_d   = 1'b1;
            stg_x_d     = x_q;
            stg_y_d     = y_q;
            stg_cells_d = i_cells;
            stg_nbrs_d  = i_nbrs;
        end

        case (state_q)
            IDLE: begin
                if (i_go || (i_run && !(i_stop_on_stable && stable_q))) begin
                    state_d   = SWEEP;
                    pop_acc_d = '0;
                    chg_d     = 1'b0;
`ifdef LIFE_RULE_PROG_EN
                    birth_d   = i_birth_mask;
                    survive_d = i_survive_mask;
`endif
                end
            end
            SWEEP: begin
                if (!i_stall) begin
                    if (x_q == XW'(FIELD_W - LANES)) begin
                        x_d = '0;
                        if (y_q == YW'(FIELD_H - 1)) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(LANES);
                    end
                end
            end
            DRAIN: begin
                if (!stg_vld_q || !i_stall) begin
                    state_d      = IDLE;
                    read_field_d = (read_field_q == FIELD_A) ? FIELD_B : FIELD_A;
                    gen_cnt_d    = gen_cnt_q + GEN_W'(1);
                    gen_done_d   = 1'b1;
                    alive_d      = pop_sum;
                    stable_d     = !chg_sum;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            stg_vld_q    <= 1'b0;
            stg_x_q      <= '0;
            stg_y_q      <= '0;
            stg_cells_q  <= '0;
            stg_nbrs_q   <= '0;
            pop_acc_q    <= '0;
            chg_q        <= 1'b0;
            read_field_q <= FIELD_A;
            gen_cnt_q    <= '0;
            alive_q      <= '0;
            gen_done_q   <= 1'b0;
            stable_q     <= 1'b0;
`ifdef LIFE_RULE_PROG_EN
            birth_q      <= '0;
            survive_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            stg_vld_q    <= stg_vld_d;
            stg_x_q      <= stg_x_d;
            stg_y_q      <= stg_y_d;
            stg_cells_q  <= stg_cells_d;
            stg_nbrs_q   <= stg_nbrs_d;
            pop_acc_q    <= pop_acc_d;
            chg_q        <= chg_d;
            read_field_q <= read_field_d;
            gen_cnt_q    <= gen_cnt_d;
            alive_q      <= alive_d;
            gen_done_q   <= gen_done_d;
            stable_q     <= stable_d;
`ifdef LIFE_RULE_PROG_EN
            birth_q      <= birth_d;
            survive_q    <= survive_d;
`endif
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_rd_en      = rd_fire;
    assign o_rd_x       = x_q;
    assign o_rd_y       = y_q;
    assign o_wr_en      = wr_fire;
    assign o_wr_x       = stg_x_q;
    assign o_wr_y       = stg_y_q;
    assign o_wr_cells   = wr_cells;
    assign o_read_field = read_field_q;
    assign o_gen_cnt    = gen_cnt_q;
    assign o_alive_cnt  = alive_q;
    assign o_gen_done   = gen_done_q;
    assign o_stable     = stable_q;

endmodule

// File: tb/tb_field_sweep_engine.sv
// Scoreboard bench for field_sweep_engine on an 8x4 field with 4 lanes and a 2-bit generation counter.
module tb_field_sweep_engine;
    import field_sweep_engine_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int L  = 4;
    localparam int GW = 2;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int AW = 6;
    localparam int NN = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_go = 1'b0;
    logic            i_run = 1'b0;
    logic            i_stop_on_stable = 1'b0;
    logic            i_stall = 1'b0;
    logic [L-1:0]    i_cells = '0;
    logic [L*NN-1:0] i_nbrs = '0;
    logic            o_busy, o_rd_en, o_wr_en, o_gen_done, o_stable;
    logic [XW-1:0]   o_rd_x, o_wr_x;
    logic [YW-1:0]   o_rd_y, o_wr_y;
    logic [L-1:0]    o_wr_cells;
    field_t          o_read_field;
    logic [GW-1:0]   o_gen_cnt;
    logic [AW-1:0]   o_alive_cnt;

    logic [8:0] b_mask = 9'b000001000;
    logic [8:0] s_mask = 9'b000001100;

    field_sweep_engine #(.FIELD_W(W), .FIELD_H(H), .LANES(L), .GEN_W(GW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_go             (i_go),
        .i_run            (i_run),
        .i_stop_on_stable (i_stop_on_stable),
        .i_stall          (i_stall),
        .i_cells          (i_cells),
        .i_nbrs           (i_nbrs),
`ifdef LIFE_RULE_PROG_EN
        .i_birth_mask     (b_mask),
        .i_survive_mask   (s_mask),
`endif
        .o_busy           (o_busy),
        .o_rd_en          (o_rd_en),
        .o_rd_x           (o_rd_x),
        .o_rd_y           (o_rd_y),
        .o_wr_en          (o_wr_en),
        .o_wr_x           (o_wr_x),
        .o_wr_y           (o_wr_y),
        .o_wr_cells       (o_wr_cells),
        .o_read_field     (o_read_field),
        .o_gen_cnt        (o_gen_cnt),
        .o_alive_cnt      (o_alive_cnt),
        .o_gen_done       (o_gen_done),
        .o_stable         (o_stable)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           x;
        int           y;
        logic [L-1:0] cells;
    } wr_t;

    typedef struct {
        int     gen;
        int     alive;
        logic   stable;
        field_t rf;
    } done_t;

    logic   mem [2][H][W];
    logic   model [H][W];
    wr_t    wr_q[$];
    done_t  done_q[$];
    int     checks = 0;
    int     failures = 0;
    int     exp_gen = 0;
    field_t exp_rf = FIELD_A;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic cell_at(input int f, input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
        return mem[f][y][x];
    endfunction

    function automatic int model_nbrs(input int x, input int y);
        int n = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    n += int'(model[y+dy][x+dx]);
        return n;
    endfunction

    function automatic logic [W-1:0] row_bits(input int f, input int y);
        logic [W-1:0] r;
        for (int x = 0; x < W; x++) r[x] = mem[f][y][x];
        return r;
    endfunction

    // Field memory: presents the cells and neighbours at the current read address.
    task automatic drive_rd();
        int f  = int'(o_read_field);
        int x0 = int'(o_rd_x);
        int y0 = int'(o_rd_y);
        for (int k = 0; k < L; k++) begin
            int n = 0;
            i_cells[k] = cell_at(f, x0 + k, y0);
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (!(dx == 0 && dy == 0)) begin
                        i_nbrs[k*NN+n] = cell_at(f, x0 + k + dx, y0 + dy);
                        n++;
                    end
        end
    endtask

    always @(posedge clk) begin
        #2;
        drive_rd();
    end

    // Monitor: compare every accepted write and every generation-end pulse against the queues.
    always @(negedge clk) begin : mon
        wr_t   e;
        done_t d;
        if (rst_n) begin
            if (o_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_x", o_wr_x, e.x);
                    check("wr_y", o_wr_y, e.y);
                    check("wr_cells", o_wr_cells, e.cells);
                end
                for (int k = 0; k < L; k++)
                    mem[1 - int'(o_read_field)][o_wr_y][int'(o_wr_x) + k] = o_wr_cells[k];
            end
            if (o_gen_done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    check("gen_cnt", o_gen_cnt, d.gen);
                    check("alive_cnt", o_alive_cnt, d.alive);
                    check("stable", o_stable, d.stable);
                    check("read_field", int'(o_read_field), int'(d.rf));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                mem[0][y][x] = 1'b0;
                mem[1][y][x] = 1'b0;
                model[y][x]  = 1'b0;
            end
    endtask

    task automatic set_cell(input int x, input int y);
        mem[int'(exp_rf)][y][x] = 1'b1;
        model[y][x] = 1'b1;
    endtask

    // Queue the expected writes and end-of-generation record for one generation.
    task automatic push_gen(input int exp_alive, input logic exp_stable);
        logic  nxt [H][W];
        wr_t   e;
        done_t d;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                nxt[y][x] = model[y][x] ? s_mask[model_nbrs(x, y)] : b_mask[model_nbrs(x, y)];
        for (int y = 0; y < H; y++)
            for (int xb = 0; xb < W; xb += L) begin
                e.x = xb;
                e.y = y;
                for (int k = 0; k < L; k++) e.cells[k] = nxt[y][xb+k];
                wr_q.push_back(e);
            end
        model   = nxt;
        exp_gen = (exp_gen + 1) % 4;
        exp_rf  = (exp_rf == FIELD_A) ? FIELD_B : FIELD_A;
        d.gen    = exp_gen;
        d.alive  = exp_alive;
        d.stable = exp_stable;
        d.rf     = exp_rf;
        done_q.push_back(d);
    endtask

    task automatic pulse_go();
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
    endtask

    task automatic wait_gen(output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_busy) n++;
            else if (n > 0) begin
                done = 1;
                break;
            end
        end
        if (!done) check("gen_timeout", 0, 1);
    endtask

    task automatic wait_rd(input int x, input int y, input string name);
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_rd_en && o_rd_x == XW'(x) && o_rd_y == YW'(y)) begin
                found = 1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        int last;
        clear_fields();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_rd_en", o_rd_en, 0);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_gen_cnt", o_gen_cnt, 0);
        check("rst_alive", o_alive_cnt, 0);
        check("rst_gen_done", o_gen_done, 0);
        check("rst_stable", o_stable, 0);
        check("rst_read_field", int'(o_read_field), int'(FIELD_A));
        tick();
        rst_n = 1'b1;
        tick();

        // Vertical blinker at x=2 flips to horizontal at y=1
        set_cell(2, 0); set_cell(2, 1); set_cell(2, 2);
        push_gen(3, 1'b0);
        pulse_go();
        wait_gen(n);
        check("blinker_busy_cycles", n, 9);
        check("blinker_row0", row_bits(1, 0), 8'b00000000);
        check("blinker_row1", row_bits(1, 1), 8'b00001110);
        check("blinker_row2", row_bits(1, 2), 8'b00000000);

        // 2x2 block in run mode with stop-on-stable halts after one generation
        clear_fields();
        set_cell(1, 1); set_cell(2, 1); set_cell(1, 2); set_cell(2, 2);
        push_gen(4, 1'b1);
        i_run = 1'b1;
        i_stop_on_stable = 1'b1;
        wait_gen(n);
        check("block_busy_cycles", n, 9);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_busy) n++;
        end
        check("stable_stays_idle", n, 0);
        tick();
        i_run = 1'b0;
        i_stop_on_stable = 1'b0;

        // Three-cycle stall after read (4,1)
        push_gen(4, 1'b1);
        pulse_go();
        wait_rd(4, 1, "rd_4_1_seen");
        tick();
        i_stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_rd_en", o_rd_en, 0);
            check("stall_wr_en", o_wr_en, 0);
            tick();
        end
        i_stall = 1'b0;
        @(negedge clk);
        check("post_stall_wr_en", o_wr_en, 1);
        check("post_stall_wr_x", o_wr_x, 4);
        check("post_stall_wr_y", o_wr_y, 1);
        check("post_stall_rd_x", o_rd_x, 0);
        check("post_stall_rd_y", o_rd_y, 2);
        wait_gen(n);

        // Asynchronous reset during the sweep at (0,2)
        push_gen(4, 1'b1);
        pulse_go();
        wait_rd(0, 2, "rd_0_2_seen");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_rd_en", o_rd_en, 0);
        check("midrst_wr_en", o_wr_en, 0);
        check("midrst_gen_cnt", o_gen_cnt, 0);
        check("midrst_read_field", int'(o_read_field), int'(FIELD_A));
        check("midrst_alive", o_alive_cnt, 0);
        wr_q.delete();
        done_q.delete();
        exp_gen = 0;
        exp_rf  = FIELD_A;
        tick();
        rst_n = 1'b1;
        tick();
        push_gen(4, 1'b1);
        pulse_go();
        @(negedge clk);
        check("restart_rd_en", o_rd_en, 1);
        check("restart_rd_x", o_rd_x, 0);
        check("restart_rd_y", o_rd_y, 0);
        check("restart_field", int'(o_read_field), int'(FIELD_A));
        wait_gen(n);

        // Counter wrap over three back-to-back generations
        clear_fields();
        set_cell(2, 0); set_cell(2, 1); set_cell(2, 2);
        push_gen(3, 1'b0);
        pulse_go();
        wait_gen(n);
        push_gen(3, 1'b0);
        pulse_go();
        wait_gen(n);
        push_gen(3, 1'b0);
        push_gen(3, 1'b0);
        push_gen(3, 1'b0);
        tick();
        i_run = 1'b1;
        pulses = 0;
        last = -1;
        for (int c = 0; c < 120 && pulses < 3; c++) begin
            @(negedge clk);
            if (o_gen_done) begin
                check("done_cycle_idle", o_busy, 0);
                if (last >= 0) check("done_spacing", c - last, 10);
                last = c;
                pulses++;
                if (pulses == 2) begin
                    @(posedge clk);
                    #1;
                    i_run = 1'b0;
                end
            end
        end
        check("run_pulses", pulses, 3);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_busy) n++;
        end
        check("run_stopped", n, 0);

`ifdef LIFE_RULE_PROG_EN
        // Programmable rule: birth on 2, never survive
        clear_fields();
        set_cell(0, 0); set_cell(2, 0);
        b_mask = 9'b000000100;
        s_mask = 9'b000000000;
        push_gen(2, 1'b0);
        pulse_go();
        wait_gen(n);
        check("prog_row0", row_bits(int'(exp_rf), 0), 8'b00000010);
        check("prog_row1", row_bits(int'(exp_rf), 1), 8'b00000010);
`endif

        repeat (3) @(negedge clk);
        check("wr_q_drained", wr_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
